// File: rtl/serial_divider.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU with a valid/ready handshake.
// Divide-by-zero and signed overflow finish on a one-cycle fast path; all other cases take WIDTH+1 cycles.
module serial_divider #(
  parameter int WIDTH        = 32,
  parameter int DIV_OP_WIDTH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    div_valid,
  input  logic [DIV_OP_WIDTH-1:0] DIVop,
  input  logic [WIDTH-1:0]        dividend,
  input  logic [WIDTH-1:0]        divisor,
  output logic                    div_ready,
  output logic [WIDTH-1:0]        div_result,
  output logic                    busy
);

  localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_DIV  = DIV_OP_WIDTH'(0);
  localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_DIVU = DIV_OP_WIDTH'(1);
  localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_REM  = DIV_OP_WIDTH'(2);
  localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_REMU = DIV_OP_WIDTH'(3);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state, next_state;
  logic               armed;
  logic [CNT_W-1:0]   counter;
  logic [WIDTH:0]     rem_reg;
  logic [WIDTH-1:0]   quot_reg;
  logic [WIDTH-1:0]   divisor_abs;
  logic               is_rem;
  logic               neg_quot;
  logic               neg_rem;

  logic               op_signed;
  logic               op_rem;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic               div_by_zero;
  logic               overflow;
  logic               fast_path;
  logic               accept;
  logic [WIDTH-1:0]   fast_result;
  logic [WIDTH+1:0]   trial;
  logic               take;
  logic [WIDTH:0]     step_rem;
  logic [WIDTH-1:0]   step_quot;
  logic [WIDTH-1:0]   final_result;

  // Request decode: operand magnitudes and the two fast-path cases
  always_comb begin
    op_signed   = (DIVop == DIV_OP_DIV) || (DIVop == DIV_OP_REM);
    op_rem      = (DIVop == DIV_OP_REM) || (DIVop == DIV_OP_REMU);
    sign_a      = op_signed & dividend[WIDTH-1];
    sign_b      = op_signed & divisor[WIDTH-1];
    abs_a       = sign_a ? -dividend : dividend;
    abs_b       = sign_b ? -divisor : divisor;
    div_by_zero = (divisor == '0);
    overflow    = op_signed && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
    fast_path   = div_by_zero || overflow;
    accept      = (state == IDLE) && div_valid && armed;
    fast_result = '0;
    if (div_by_zero)
      fast_result = op_rem ? dividend : '1;
    else if (!op_rem)
      fast_result = {1'b1, {(WIDTH-1){1'b0}}};
  end

  // One restoring step; the sign fix is applied to the result of the last step
  always_comb begin
    trial        = {rem_reg, quot_reg[WIDTH-1]} - {2'b00, divisor_abs};
    take         = ~trial[WIDTH+1];
    step_rem     = take ? trial[WIDTH:0] : {rem_reg[WIDTH-1:0], quot_reg[WIDTH-1]};
    step_quot    = {quot_reg[WIDTH-2:0], take};
    final_result = is_rem ? (neg_rem ? -step_rem[WIDTH-1:0] : step_rem[WIDTH-1:0])
                          : (neg_quot ? -step_quot : step_quot);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = fast_path ? DONE : CALC;
      CALC: begin
        if (!div_valid)
          next_state = IDLE;
        else if (counter == '0)
          next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    div_ready = (state == DONE);
    busy      = (state == CALC);
  end

  // armed blocks re-acceptance of a request that is still held after completion
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed       <= 1'b1;
      counter     <= '0;
      rem_reg     <= '0;
      quot_reg    <= '0;
      divisor_abs <= '0;
      is_rem      <= 1'b0;
      neg_quot    <= 1'b0;
      neg_rem     <= 1'b0;
      div_result  <= '0;
    end else begin
      if (!div_valid)
        armed <= 1'b1;
      else if (accept)
        armed <= 1'b0;

      if (accept) begin
        counter     <= CNT_W'(WIDTH-1);
        rem_reg     <= '0;
        quot_reg    <= abs_a;
        divisor_abs <= abs_b;
        is_rem      <= op_rem;
        neg_quot    <= sign_a ^ sign_b;
        neg_rem     <= sign_a;
        if (fast_path)
          div_result <= fast_result;
      end else if (state == CALC && div_valid) begin
        rem_reg  <= step_rem;
        quot_reg <= step_quot;
        if (counter == '0)
          div_result <= final_result;
        else
          counter <= counter - 1'b1;
      end
    end
  end

endmodule

// File: doc/serial_divider.md
# serial_divider

Multi-cycle restoring divider that responds to the CPU's `div_valid`/`div_ready` handshake and executes RV32M DIV, DIVU, REM and REMU. It sits beside the multiplier in the datapath. The control FSM raises `div_valid` and holds it, together with `DIVop` and the operands, until this block pulses `div_ready` with the result. The block handles RISC-V divide-by-zero and signed-overflow cases on a single-cycle fast path. All other operations finish in a fixed WIDTH+1 cycles.

## Interface
- `WIDTH`, 32: operand/result width; also the iteration count.
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `div_valid`  in  1  request from control unit; held high until `div_ready` is seen.
- `DIVop`  in  `DIV_OP_WIDTH`  operation select: `DIV_OP_DIV`, `DIV_OP_DIVU`, `DIV_OP_REM`, `DIV_OP_REMU` (riscv_defines.vh).
- `dividend`  in  WIDTH  rs1 value.
- `divisor`  in  WIDTH  rs2 value.
- `div_ready`  out  1  one-cycle completion pulse.
- `div_result`  out  WIDTH  quotient or remainder; valid while `div_ready`=1, held until next acceptance.
- `busy`  out  1  high in CALC.

## Operation
- States: IDLE, CALC, DONE. `armed` flag (1 after reset).
- IDLE: on `div_valid`=1 and `armed`=1 the block accepts. At acceptance it latches op, signs, |dividend|, |divisor|, sets counter=WIDTH-1, and clears `armed`.
- Absolute values: |x| = two's-complement negate when signed op and x[WIDTH-1]=1. 0x80000000 stays 0x80000000 and is treated as unsigned 2^31.
- Fast path (IDLE→DONE directly) applies in two cases:
  - divisor==0: quotient = all ones, remainder = dividend (unmodified).
  - Signed op, dividend==0x80000000 and divisor==all ones: quotient = 0x80000000, remainder = 0.
- CALC: one restoring step per cycle, using a WIDTH+1-bit partial remainder R and quotient shift register Q.
  - {R,Q} shifted left 1; trial = R − |divisor|.
  - If trial ≥ 0: R=trial and Q[0]=1; else Q[0]=0.
  - Counter decrements each step. When counter==0, the final step is taken and the state moves to DONE.
- Sign fix on CALC→DONE:
  - DIV quotient is negated when sign(dividend)≠sign(divisor).
  - REM remainder is negated when dividend negative.
  - Unsigned ops: no fix.
- DONE: `div_ready`=1 for exactly one cycle, then IDLE. `div_result` is registered and holds its value afterwards.
- `armed` is set in any cycle where `div_valid`=0. A request still held high after `div_ready` is therefore never re-accepted.
- Abort: `div_valid`=0 during CALC → return to IDLE next cycle. No `div_ready` is produced and `div_result` is unchanged.
- Operand/`DIVop` changes after acceptance are ignored.

## Timing
- Reset (async, immediate): state=IDLE, `div_ready`=0, `div_result`=0, `busy`=0, `armed`=1, counter=0, internal registers=0.
- Cycle 0 = first IDLE cycle with `div_valid`=1 and `armed`=1.
- Normal path: CALC in cycles 1..WIDTH; `div_ready`=1 in cycle WIDTH+1 (33 at WIDTH=32).
- Fast path: `div_ready`=1 in cycle 1.
- `busy`=1 exactly in cycles 1..WIDTH; 0 in IDLE and DONE.
- Back-to-back operations:
  - Earliest acceptance after DONE is the first IDLE cycle with `div_valid`=1 following at least one cycle of `div_valid`=0.
  - A `div_valid`=0 cycle coincident with DONE counts.
- Reset asserted mid-CALC: outputs take reset values immediately; no `div_ready` for the aborted op.
- Deassertion of reset: the first acceptance is possible on the first clock edge after reset is low.

## Test plan
- DIVU 100/7: `div_ready` in cycle 33 with `div_result`=14. REMU 100/7 → 2. `busy` high in cycles 1–32 only.
- DIV −7/2: result 0xFFFFFFFD. REM −7/2: result 0xFFFFFFFF. DIV 7/−2: result 0xFFFFFFFD. REM 7/−2: result 1.
- Divide by zero:
  - DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5; DIV −5/0 → 0xFFFFFFFF; REM −5/0 → 0xFFFFFFFB.
  - All complete in cycle 1.
- Signed overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0. Cycle 1. DIVU same operands → 0 at cycle 33.
- Handshake:
  - Hold `div_valid` high for 10 cycles after `div_ready` → no second pulse.
  - Drop it one cycle, then raise with DIVU 9/3 → result 3 at 33 cycles after re-acceptance.
- Abort/reset:
  - Drop `div_valid` at cycle 10 → no `div_ready` and `div_result` unchanged.
  - Assert `reset` at cycle 15 of a new op → `div_ready`=0, `div_result`=0, `busy`=0 immediately.
  - Next request after reset release completes normally.
